// File: rtl/iq_freelist_ctrl.sv
// iq_freelist_ctrl: circular free-list of issue-queue entry IDs.
// Freed IDs are accepted from the freeing selector; IDs are granted to dispatch all-or-nothing.
// A reset or flush re-initialises the pool with every ID, FREEING_WIDTH IDs per cycle.
// Optional macro IQ_FREELIST_DUPCHECK_EN adds an in-pool vector and the sticky dupFree_o output.
module iq_freelist_ctrl #(
  parameter int unsigned SIZE_ISSUEQ     = 32,
  parameter int unsigned SIZE_ISSUEQ_LOG = 5,
  parameter int unsigned DISPATCH_WIDTH  = 4,
  parameter int unsigned FREEING_WIDTH   = 4
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic                                       flush_i,
  input  logic                                       dispatchReq_i,
  input  logic [$clog2(DISPATCH_WIDTH):0]            numDispatch_i,
  input  logic [FREEING_WIDTH-1:0]                   freedValid_i,
  input  logic [FREEING_WIDTH*SIZE_ISSUEQ_LOG-1:0]   freedId_i,
  output logic [DISPATCH_WIDTH*SIZE_ISSUEQ_LOG-1:0]  allocId_o,
  output logic [DISPATCH_WIDTH-1:0]                  allocValid_o,
  output logic                                       stall_o,
  output logic [SIZE_ISSUEQ_LOG:0]                   freeCount_o,
  output logic                                       initBusy_o,
`ifdef IQ_FREELIST_DUPCHECK_EN
  output logic                                       dupFree_o,
`endif
  output logic                                       overflow_o
);

  localparam int unsigned LOG_W     = SIZE_ISSUEQ_LOG;
  localparam int unsigned CNT_W     = SIZE_ISSUEQ_LOG + 1;
  localparam int unsigned ND_W      = $clog2(DISPATCH_WIDTH) + 1;
  localparam int unsigned SUM_W     = CNT_W + 1;
  localparam int unsigned INIT_LAST = SIZE_ISSUEQ - FREEING_WIDTH;

  typedef enum logic {INIT, READY} state_t;

  state_t                 state;
  state_t                 stateNext;
  logic [LOG_W-1:0]       freeBuf [SIZE_ISSUEQ];
  logic [LOG_W-1:0]       initPtr;
  logic [LOG_W-1:0]       head;
  logic [LOG_W-1:0]       tail;
  logic [CNT_W-1:0]       count;
  logic                   overflow;
  logic                   initLast;
  logic                   stallC;
  logic                   alloc;
  logic [CNT_W-1:0]       allocCnt;
  logic [SUM_W-1:0]       room;
  logic [SUM_W-1:0]       accCnt;
  logic [CNT_W-1:0]       countNext;
  logic                   ovfHit;
  logic [FREEING_WIDTH-1:0] wrEn;
  logic [LOG_W-1:0]       wrOff [FREEING_WIDTH];
  logic                   bufWe [SIZE_ISSUEQ];
  logic [LOG_W-1:0]       bufWd [SIZE_ISSUEQ];
`ifdef IQ_FREELIST_DUPCHECK_EN
  logic [SIZE_ISSUEQ-1:0] inPool;
  logic [SIZE_ISSUEQ-1:0] inPoolNext;
  logic                   dupHit;
  logic                   dupFree;
`endif

  assign initLast = (initPtr == LOG_W'(INIT_LAST));

  // State register: reset forces re-initialisation
  always_ff @(posedge clk) begin
    if (!reset) state <= INIT;
    else        state <= stateNext;
  end

  // Next state: flush restarts INIT from any state, INIT ends after the last group
  always_comb begin
    stateNext = state;
    if (flush_i)                         stateNext = INIT;
    else if (state == INIT && initLast)  stateNext = READY;
  end

  // Dispatch grant, stall and head-window outputs
  always_comb begin
    stallC   = (state == INIT) || (dispatchReq_i && (CNT_W'(numDispatch_i) > count));
    alloc    = (state == READY) && dispatchReq_i && !stallC && !flush_i;
    allocCnt = alloc ? CNT_W'(numDispatch_i) : '0;
    for (int k = 0; k < int'(DISPATCH_WIDTH); k++) begin
      allocValid_o[k]                = alloc && (ND_W'(k) < numDispatch_i);
      allocId_o[k*LOG_W +: LOG_W]    = freeBuf[head + LOG_W'(k)];
    end
  end

  assign stall_o     = stallC;
  assign initBusy_o  = (state == INIT);
  assign freeCount_o = count;
  assign overflow_o  = overflow;

  // Freed-lane compaction, capacity limiting and optional duplicate filtering
  always_comb begin
    logic [LOG_W-1:0] laneId;
    logic             laneOk;
`ifdef IQ_FREELIST_DUPCHECK_EN
    logic [SIZE_ISSUEQ-1:0] seen;
    seen       = inPool;
    dupHit     = 1'b0;
    inPoolNext = inPool;
    for (int k = 0; k < int'(DISPATCH_WIDTH); k++) begin
      if (allocValid_o[k]) inPoolNext[freeBuf[head + LOG_W'(k)]] = 1'b0;
    end
`endif
    room   = SUM_W'(SIZE_ISSUEQ) - SUM_W'(count) + SUM_W'(allocCnt);
    accCnt = '0;
    ovfHit = 1'b0;
    wrEn   = '0;
    laneId = '0;
    laneOk = 1'b0;
    for (int k = 0; k < int'(FREEING_WIDTH); k++) begin
      wrOff[k] = '0;
      laneId   = freedId_i[k*LOG_W +: LOG_W];
      laneOk   = (state == READY) && !flush_i && freedValid_i[k];
`ifdef IQ_FREELIST_DUPCHECK_EN
      if (laneOk) begin
        if (seen[laneId]) begin
          dupHit = 1'b1;
          laneOk = 1'b0;
        end else begin
          seen[laneId] = 1'b1;
        end
      end
`endif
      if (laneOk) begin
        if (accCnt < room) begin
          wrEn[k]  = 1'b1;
          wrOff[k] = LOG_W'(accCnt);
          accCnt   = accCnt + SUM_W'(1);
`ifdef IQ_FREELIST_DUPCHECK_EN
          inPoolNext[laneId] = 1'b1;
`endif
        end else begin
          ovfHit = 1'b1;
        end
      end
    end
    countNext = CNT_W'(SUM_W'(count) - SUM_W'(allocCnt) + accCnt);
  end

  // Per-entry buffer write enables: INIT group fill or compacted frees at tail
  always_comb begin
    for (int e = 0; e < int'(SIZE_ISSUEQ); e++) begin
      bufWe[e] = 1'b0;
      bufWd[e] = '0;
    end
    if (reset && !flush_i && state == INIT) begin
      for (int k = 0; k < int'(FREEING_WIDTH); k++) begin
        bufWe[initPtr + LOG_W'(k)] = 1'b1;
        bufWd[initPtr + LOG_W'(k)] = initPtr + LOG_W'(k);
      end
    end else if (reset) begin
      for (int k = 0; k < int'(FREEING_WIDTH); k++) begin
        if (wrEn[k]) begin
          bufWe[tail + wrOff[k]] = 1'b1;
          bufWd[tail + wrOff[k]] = freedId_i[k*LOG_W +: LOG_W];
        end
      end
    end
  end

  // ID storage
  always_ff @(posedge clk) begin
    for (int e = 0; e < int'(SIZE_ISSUEQ); e++) begin
      if (bufWe[e]) freeBuf[e] <= bufWd[e];
    end
  end

  // Pointers, count and sticky error flags
  always_ff @(posedge clk) begin
    if (!reset) begin
      initPtr  <= '0;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      overflow <= 1'b0;
`ifdef IQ_FREELIST_DUPCHECK_EN
      inPool   <= '0;
      dupFree  <= 1'b0;
`endif
    end else if (flush_i) begin
      initPtr  <= '0;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
`ifdef IQ_FREELIST_DUPCHECK_EN
      inPool   <= '0;
`endif
    end else if (state == INIT) begin
      initPtr <= initPtr + LOG_W'(FREEING_WIDTH);
      if (initLast) begin
        head  <= '0;
        tail  <= '0;
        count <= CNT_W'(SIZE_ISSUEQ);
`ifdef IQ_FREELIST_DUPCHECK_EN
        inPool <= '1;
`endif
      end
    end else begin
      head  <= head + LOG_W'(allocCnt);
      tail  <= tail + LOG_W'(accCnt);
      count <= countNext;
      if (ovfHit) overflow <= 1'b1;
`ifdef IQ_FREELIST_DUPCHECK_EN
      inPool <= inPoolNext;
      if (dupHit) dupFree <= 1'b1;
`endif
    end
  end

`ifdef IQ_FREELIST_DUPCHECK_EN
  assign dupFree_o = dupFree;
`endif

endmodule

// File: tb/tb_iq_freelist_ctrl.sv
// Scoreboard bench for iq_freelist_ctrl: a queue model of the free pool supplies expected grants.
module tb_iq_freelist_ctrl;

  localparam int unsigned SIZE = 32;
  localparam int unsigned LOGW = 5;
  localparam int unsigned DW   = 4;
  localparam int unsigned FW   = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              flush;
  logic              dispatchReq;
  logic [2:0]        numDispatch;
  logic [FW-1:0]     freedValid;
  logic [FW*LOGW-1:0] freedId;
  logic [DW*LOGW-1:0] allocId;
  logic [DW-1:0]     allocValid;
  logic              stall;
  logic [LOGW:0]     freeCount;
  logic              initBusy;
  logic              overflow;
`ifdef IQ_FREELIST_DUPCHECK_EN
  logic              dupFree;
`endif

  iq_freelist_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .flush_i       (flush),
    .dispatchReq_i (dispatchReq),
    .numDispatch_i (numDispatch),
    .freedValid_i  (freedValid),
    .freedId_i     (freedId),
    .allocId_o     (allocId),
    .allocValid_o  (allocValid),
    .stall_o       (stall),
    .freeCount_o   (freeCount),
    .initBusy_o    (initBusy),
`ifdef IQ_FREELIST_DUPCHECK_EN
    .dupFree_o     (dupFree),
`endif
    .overflow_o    (overflow)
  );

  always #5 clk = ~clk;

  int          nCompared = 0;
  int          nMismatched = 0;
  int unsigned pool[$];
  int unsigned sbQ[$];
  int          initLeft = 0;
  bit          ovfModel = 0;
  bit          dupModel = 0;

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nCompared++;
    if (got !== exp) begin
      nMismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [FW*LOGW-1:0] ids4(input int a, input int b, input int c, input int d);
    return {5'(d), 5'(c), 5'(b), 5'(a)};
  endfunction

  // One clock: drive, predict, check combinational/registered outputs, then advance the model
  task automatic step(input logic req, input int nd, input logic [FW-1:0] fv,
                      input logic [FW*LOGW-1:0] fids, input logic fl);
    bit            inInit;
    bit            expStall;
    bit            doAlloc;
    logic [DW-1:0] expValid;
    int            room;
    bit [SIZE-1:0] seenV;
    int unsigned   id;
    bit            ok;
    dispatchReq = req;
    numDispatch = 3'(nd);
    freedValid  = fv;
    freedId     = fids;
    flush       = fl;
    inInit   = (initLeft > 0);
    expStall = inInit || (req && (nd > pool.size()));
    doAlloc  = !inInit && req && !expStall && !fl;
    expValid = doAlloc ? 4'((1 << nd) - 1) : 4'b0;
    if (doAlloc) for (int k = 0; k < nd; k++) sbQ.push_back(pool[k]);
    #2;
    checkVal("stall", 64'(stall), 64'(expStall));
    checkVal("initBusy", 64'(initBusy), 64'(inInit));
    checkVal("freeCount", 64'(freeCount), 64'(pool.size()));
    checkVal("overflow", 64'(overflow), 64'(ovfModel));
`ifdef IQ_FREELIST_DUPCHECK_EN
    checkVal("dupFree", 64'(dupFree), 64'(dupModel));
`endif
    checkVal("allocValid", 64'(allocValid), 64'(expValid));
    for (int k = 0; k < int'(DW); k++) begin
      if (expValid[k]) checkVal("allocId", 64'(allocId[k*LOGW +: LOGW]), 64'(sbQ.pop_front()));
      else if (!inInit && !doAlloc && k < pool.size())
        checkVal("peekId", 64'(allocId[k*LOGW +: LOGW]), 64'(pool[k]));
    end
    @(posedge clk);
    if (fl) begin
      initLeft = 8;
      pool.delete();
    end else if (inInit) begin
      initLeft--;
      if (initLeft == 0) for (int i = 0; i < int'(SIZE); i++) pool.push_back(i);
    end else begin
      seenV = '0;
      foreach (pool[i]) seenV[pool[i]] = 1'b1;
      if (doAlloc) repeat (nd) void'(pool.pop_front());
      room = int'(SIZE) - pool.size();
      for (int k = 0; k < int'(FW); k++) begin
        if (fv[k]) begin
          id = int'(fids[k*LOGW +: LOGW]);
          ok = 1;
`ifdef IQ_FREELIST_DUPCHECK_EN
          if (seenV[id]) begin dupModel = 1; ok = 0; end
          else seenV[id] = 1'b1;
`endif
          if (ok) begin
            if (room > 0) begin pool.push_back(id); room--; end
            else ovfModel = 1;
          end
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, 0, '0, '0, 1'b0);
  endtask

  initial begin
    reset = 1'b0; flush = 1'b0; dispatchReq = 1'b0; numDispatch = '0;
    freedValid = '0; freedId = '0;
    @(negedge clk);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2;
    checkVal("rst_initBusy", 64'(initBusy), 64'd1);
    checkVal("rst_stall", 64'(stall), 64'd1);
    checkVal("rst_freeCount", 64'(freeCount), 64'd0);
    checkVal("rst_overflow", 64'(overflow), 64'd0);
    checkVal("rst_allocValid", 64'(allocValid), 64'd0);
    reset = 1'b1;
    initLeft = 8;

    // Initialisation sweep, then first window
    repeat (8) idle();
    idle();
    // Allocate three, observe the advanced head
    step(1'b1, 3, '0, '0, 1'b0);
    idle();
    // Drain to two free entries
    repeat (6) step(1'b1, 4, '0, '0, 1'b0);
    step(1'b1, 3, '0, '0, 1'b0);
    // Stall with simultaneous free of 7 and 9, then a successful retry
    step(1'b1, 4, 4'b0101, ids4(7, 0, 9, 0), 1'b0);
    step(1'b1, 4, '0, '0, 1'b0);
    // Empty pool behaviour
    step(1'b1, 1, '0, '0, 1'b0);
    step(1'b1, 0, '0, '0, 1'b0);
    // Steady-state alloc/free through the wrap point
    step(1'b0, 0, 4'b1111, ids4(0, 1, 2, 3), 1'b0);
    for (int i = 0; i < 8; i++) begin
      int b;
      b = 4 * (i + 1);
      step(1'b1, 4, 4'b1111, ids4(b % 32, (b + 1) % 32, (b + 2) % 32, (b + 3) % 32), 1'b0);
    end
    idle();
    // Flush, then flush again mid-initialisation while frees are presented
    step(1'b0, 0, '0, '0, 1'b1);
    repeat (4) step(1'b1, 2, 4'b1111, ids4(1, 2, 3, 4), 1'b0);
    step(1'b0, 0, 4'b0011, ids4(5, 6, 0, 0), 1'b1);
    repeat (8) step(1'b1, 1, 4'b1010, ids4(0, 8, 0, 9), 1'b0);
    idle();
    // Free into a full pool
    step(1'b0, 0, 4'b0001, ids4(5, 0, 0, 0), 1'b0);
    idle();
    idle();
    // Randomised traffic
    for (int i = 0; i < 80; i++) begin
      step(1'($urandom_range(0, 1)), int'($urandom_range(0, 4)), 4'($urandom),
           20'($urandom), ($urandom_range(0, 39) == 0));
    end
    checkVal("sb_left", 64'(sbQ.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/iq_freelist_ctrl.md
Name: iq_freelist_ctrl

Overview:
- Manages the pool of free issue-queue entry IDs between freeing and dispatch.
- Holds free IQ IDs in a circular buffer.
- Accepts up to FREEING_WIDTH freed IDs per cycle from the IQ freeing selector.
- Grants up to DISPATCH_WIDTH IDs per cycle to dispatch on an all-or-nothing basis.
- On reset or pipeline flush, runs a multi-cycle re-initialisation that refills the pool with every ID.

Parameters:
- SIZE_ISSUEQ, 32, number of IQ entries; must be a power of two.
- SIZE_ISSUEQ_LOG, 5, log2(SIZE_ISSUEQ).
- DISPATCH_WIDTH, 4, maximum IDs allocated per cycle.
- FREEING_WIDTH, 4, maximum IDs returned per cycle; must divide SIZE_ISSUEQ.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset (asserted when 0).
- flush_i  in  1  mispredict/exception flush; the IQ is emptied.
- dispatchReq_i  in  1  dispatch bundle is presented this cycle.
- numDispatch_i  in  log2(DISPATCH_WIDTH)+1  number of IDs requested, 0..DISPATCH_WIDTH.
- freedValid_i  in  FREEING_WIDTH  per-lane freed-ID valid.
- freedId_i  in  FREEING_WIDTH*SIZE_ISSUEQ_LOG  per-lane freed IDs.
- allocId_o  out  DISPATCH_WIDTH*SIZE_ISSUEQ_LOG  next IDs at head..head+DW-1.
- allocValid_o  out  DISPATCH_WIDTH  lane k is granted this cycle.
- stall_o  out  1  request cannot be satisfied; dispatch must hold.
- freeCount_o  out  SIZE_ISSUEQ_LOG+1  current free-ID count.
- initBusy_o  out  1  re-initialisation in progress.
- overflow_o  out  1  sticky: a free would push the count beyond SIZE_ISSUEQ.

Behaviour:
- State machine INIT / READY.
  - reset=0 forces INIT with initPtr=0, head=0, tail=0, count=0 and overflow_o=0.
  - flush_i=1 in any state forces INIT with initPtr=0. A flush during INIT restarts INIT.
- INIT:
  - Each cycle writes buf[initPtr+k]=initPtr+k for k in 0..FREEING_WIDTH-1, then initPtr += FREEING_WIDTH.
  - On the cycle the last group is written, the next state is READY with head=0, tail=0, count=SIZE_ISSUEQ.
  - INIT lasts SIZE_ISSUEQ/FREEING_WIDTH cycles (8 at defaults).
  - During INIT: initBusy_o=1, stall_o=1, allocValid_o=0, and freed inputs are ignored (the IQ is empty after a flush).
- READY:
  - allocId_o lane k = buf[(head+k) mod SIZE] combinationally, valid or not.
  - stall_o = dispatchReq_i && (numDispatch_i > count), combinational.
  - alloc = dispatchReq_i && !stall_o && !flush_i.
  - allocValid_o[k] = alloc && (k < numDispatch_i).
  - On alloc: head += numDispatch_i, mod SIZE.
- Freeing (READY, no flush):
  - Valid lanes are compacted in ascending lane order and written at tail, tail+1, ...
  - tail += popcount(freedValid_i), mod SIZE.
  - Freed IDs are not visible on allocId_o until the following cycle, even when count is low.
- Count:
  - count_next = count - (alloc ? numDispatch_i : 0) + nFreed.
  - Width is SIZE_ISSUEQ_LOG+1; wrap-around of head/tail is implicit via power-of-two masking.
  - If count_next > SIZE_ISSUEQ: set overflow_o (sticky until reset), saturate count at SIZE_ISSUEQ, and write only the first (SIZE - count + allocated) compacted IDs. tail advances by that amount.
- Simultaneous alloc and free in the same cycle is legal; both pointer updates and the net count apply.
- Empty (count=0): any numDispatch_i>0 stalls. numDispatch_i=0 with dispatchReq_i=1 never stalls and allocates nothing.
- Full (count=SIZE): any valid freed lane triggers overflow.
- Reset output values: allocValid_o=0, stall_o=1 (INIT), initBusy_o=1, freeCount_o=0, overflow_o=0. allocId_o is don't-care.

Optional Feature:
- Macro IQ_FREELIST_DUPCHECK_EN.
- When defined:
  - Keeps a SIZE_ISSUEQ-bit inPool vector: set for all IDs at INIT completion, set on free, cleared on alloc.
  - A freed ID whose bit is already set, or two lanes freeing the same ID in one cycle, sets sticky output dupFree_o and drops that lane (not written, not counted).
- When undefined: no vector, no dupFree_o port; all valid lanes are accepted.

Test Plan:
- Release reset, no traffic -> initBusy_o=1 for 8 cycles, then freeCount_o=32 and allocId_o={0,1,2,3}.
- After init, dispatchReq_i=1, numDispatch_i=3 -> allocValid_o=0111 and IDs {0,1,2}; next cycle freeCount_o=29 and allocId_o lane0=3.
- With count=2: request 4 -> stall_o=1, allocValid_o=0, count stays 2. Same cycle free lanes 0 and 2 with IDs 7,9 -> next cycle count=4, and a repeated request succeeds with the last two IDs being 7,9.
- Allocate 4/cycle for 8 cycles while freeing 4/cycle -> head/tail wrap past 31 to 0 correctly, and the IDs returned match free order.
- Flush mid-INIT at cycle 5 -> INIT restarts, READY only 8 cycles after the flush, and freed inputs during INIT do not change count.
- At count=32, free one ID -> overflow_o=1 (sticky), count stays 32. With IQ_FREELIST_DUPCHECK_EN, freeing ID 5 while it is still in the pool -> dupFree_o=1 and count unchanged.
